// File: rtl/mem_dcache.sv
// Memory-stage data cache: direct-mapped, write-through, no-write-allocate.
// Whole-line refills over a req/ack port; BUSY freezes the pipeline while a miss or store is outstanding.
module mem_dcache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MEM,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic        BUSY,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t             state;
    logic [OFF_W-1:0]   cnt;
    logic [OFF_W-1:0]   cnt_nxt;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES][WORDS];

    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               is_load, is_store, hit;
    logic               busy_c;
    logic               unused_addr;

    assign off         = Addr[OFF_W+1:2];
    assign idx         = Addr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag         = Addr[31:32-TAG_W];
    assign is_load     = (MEM == 2'b01);
    assign is_store    = (MEM == 2'b10);
    assign hit         = valid[idx] && (tag_mem[idx] == tag);
    assign cnt_nxt     = cnt + 1'b1;
    assign unused_addr = ^Addr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load && !hit) begin
                        // Invalidate up front so a half-filled line can never hit.
                        valid[idx] <= 1'b0;
                        cnt        <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {tag, idx, {OFF_W{1'b0}}, 2'b00};
                        state      <= REFILL;
                    end else if (is_store) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {Addr[31:2], 2'b00};
                        mem_wdata <= Wdata;
                        state     <= WRITE;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST) begin
                            valid[idx] <= 1'b1;
                            mem_req    <= 1'b0;
                            state      <= DONE;
                        end else begin
                            mem_addr <= {tag, idx, cnt_nxt, 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) begin
            data_mem[idx][cnt] <= mem_rdata;
            if (cnt == LAST)
                tag_mem[idx] <= tag;
        end
        if (state == WRITE && mem_ack && hit)
            data_mem[idx][off] <= Wdata;
    end

    always_comb begin
        busy_c = 1'b0;
        case (state)
            IDLE:         busy_c = (is_load && !hit) || is_store;
            REFILL, WRITE: busy_c = 1'b1;
            default:      busy_c = 1'b0;
        endcase
    end

    assign BUSY = rst && busy_c;

    always_comb begin
        Rdata = '0;
        if (rst && is_load && ((state == IDLE && hit) || state == DONE))
            Rdata = data_mem[idx][off];
    end

endmodule

// File: tb/tb_mem_dcache.sv
// Randomized bench for mem_dcache: residency/backing-memory reference model plus a req/ack memory responder.
module tb_mem_dcache;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int LSH   = 2 + $clog2(WORDS);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  MEM = 2'b00;
    logic [31:0] Addr = '0, Wdata = '0;
    logic [31:0] Rdata;
    logic        BUSY, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk = 0, n_err = 0;
    int ack_lat = 1;

    logic [31:0] bmem [int];
    logic [31:0] rmem [int];
    int          resident [LINES];
    logic [31:0] log_addr [$];
    logic [31:0] log_wdata [$];
    logic        log_we [$];

    mem_dcache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .MEM(MEM), .Addr(Addr), .Wdata(Wdata), .Rdata(Rdata),
        .BUSY(BUSY), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seed_val(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input int w);
        return rmem.exists(w) ? rmem[w] : seed_val(w);
    endfunction

    function automatic logic [31:0] bmem_rd(input int w);
        return bmem.exists(w) ? bmem[w] : seed_val(w);
    endfunction

    // Backing memory: acks after ack_lat idle cycles of each request.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst || !mem_req) begin
                mem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= ack_lat) begin
                mem_ack = 1'b1;
                mem_rdata = mem_we ? 32'h0 : bmem_rd(int'(mem_addr >> 2));
                if (mem_we) bmem[int'(mem_addr >> 2)] = mem_wdata;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wdata.push_back(mem_wdata);
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
    endtask

    // Called at posedge+1 with the cache idle; returns at posedge+1 after the op retires.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input int lat);
        int line, idx, busy, exp_busy;
        bit is_ld, is_st, hit;
        logic [31:0] base;
        line  = int'(a >> LSH);
        idx   = line % LINES;
        hit   = (resident[idx] == line);
        is_ld = (op == 2'b01);
        is_st = (op == 2'b10);
        base  = a & ~32'(WORDS * 4 - 1);
        exp_busy = is_st ? lat + 2 : (is_ld && !hit) ? 1 + WORDS * (lat + 1) : 0;

        ack_lat = lat;
        clear_log();
        MEM = op; Addr = a; Wdata = d;
        busy = 0;
        @(negedge clk);
        while (BUSY === 1'b1 && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        chk($sformatf("busy_cycles op%0d @%h", op, a), 32'(busy), 32'(exp_busy));
        chk($sformatf("rdata @%h", a), Rdata, is_ld ? ref_rd(int'(a >> 2)) : 32'h0);
        chk("req_low_at_retire", 32'(mem_req), 32'h0);

        if (is_ld && !hit) begin
            chk("refill_words", 32'(log_addr.size()), 32'(WORDS));
            for (int k = 0; k < log_addr.size() && k < WORDS; k++) begin
                chk($sformatf("refill_addr%0d", k), log_addr[k], base + 32'(4 * k));
                chk($sformatf("refill_we%0d", k), 32'(log_we[k]), 32'h0);
            end
            resident[idx] = line;
        end else if (is_st) begin
            chk("store_beats", 32'(log_addr.size()), 32'h1);
            if (log_addr.size() > 0) begin
                chk("store_addr", log_addr[0], a & ~32'h3);
                chk("store_we", 32'(log_we[0]), 32'h1);
                chk("store_wdata", log_wdata[0], d);
            end
            rmem[int'(a >> 2)] = d;
        end else begin
            chk("no_mem_traffic", 32'(log_addr.size()), 32'h0);
        end

        @(posedge clk); #1;
        MEM = 2'b00;
    endtask

    initial begin
        int g;
        foreach (resident[k]) resident[k] = -1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", Rdata, 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'h100, 32'h0, 1);          // cold miss, 9 busy cycles
        run_op(2'b01, 32'h108, 32'h0, 1);          // hit in the new line
        run_op(2'b10, 32'h104, 32'hDEAD_BEEF, 0);  // store hit, 2 busy cycles
        run_op(2'b01, 32'h104, 32'h0, 1);          // sees stored value
        run_op(2'b10, 32'h2000, 32'h1234_5678, 1); // store miss: no allocate
        run_op(2'b01, 32'h2000, 32'h0, 1);         // so this misses
        run_op(2'b01, 32'h100, 32'h0, 1);          // 0x2000 evicted line 0
        run_op(2'b01, 32'h500, 32'h0, 2);          // conflict on idx 0
        run_op(2'b01, 32'h100, 32'h0, 0);          // misses again
        run_op(2'b11, 32'h100, 32'h0, 1);          // 2'b11 behaves as no-op
        run_op(2'b00, 32'h104, 32'h0, 1);

        // Reset in the 3rd word of a refill.
        ack_lat = 1;
        clear_log();
        MEM = 2'b01; Addr = 32'h300; Wdata = '0;
        g = 0;
        do begin
            @(negedge clk); #1;
            g++;
        end while (log_addr.size() < 2 && g < 50);
        chk("rst_mid_setup", 32'(log_addr.size()), 32'h2);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 32'h0);
        chk("rst_mid_busy", 32'(BUSY), 32'h0);
        chk("rst_mid_rdata", Rdata, 32'h0);
        @(posedge clk); #1;
        MEM = 2'b00;
        rst = 1'b1;
        foreach (resident[k]) resident[k] = -1;
        run_op(2'b01, 32'h100, 32'h0, 1);          // all lines invalid after reset
        run_op(2'b01, 32'h304, 32'h0, 1);          // partial line is not a hit

        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] op;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            op = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            a  = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | 32'h0001_0000;
            run_op(op, a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
